// File: rtl/cmp_classify_pipe.sv
// cmp_classify_pipe: two-stage multi-channel compare/classify pipeline with
// per-channel last-code history and saturating per-code hit counters.
module cmp_classify_pipe #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 9,
  parameter int SIGNED    = 0,
  localparam int CW       = $clog2(CHANNELS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CW-1:0]        in_chan,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_chan,
  output logic [1:0]           out_code,
  input  logic                 clear,
  input  logic [CW-1:0]        rd_chan,
  input  logic [1:0]           rd_sel,
  output logic [CNT_WIDTH-1:0] rd_count
);
  localparam logic [CW:0] CH = (CW+1)'(CHANNELS);
  logic                                       s1_valid_q, s1_valid_d, s1_gt_q, s1_gt_d;
  logic                                       s1_eq_q, s1_eq_d, s1_oor_q, s1_oor_d;
  logic [CW-1:0]                              s1_chan_q, s1_chan_d;
  logic                                       out_valid_q, out_valid_d;
  logic [CW-1:0]                              out_chan_q, out_chan_d;
  logic [1:0]                                 out_code_q, out_code_d;
  logic [CHANNELS-1:0][1:0]                   last_code_q, last_code_d;
  logic [CHANNELS-1:0][3:0][CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]                       rd_count_q, rd_count_d, cur;
  logic                                       s2_load, in_fire, gt;
  logic [1:0]                                 prev, code;
  always_comb begin
    gt = (SIGNED != 0) ? ($signed(in_a) > $signed(in_b)) : (in_a > in_b);
    s2_load = s1_valid_q && (!out_valid_q || out_ready);
    in_ready = !s1_valid_q || s2_load;
    in_fire = in_valid && in_ready;
    s1_valid_d = in_fire || (s1_valid_q && !s2_load);
    s1_chan_d = in_fire ? in_chan : s1_chan_q;
    s1_gt_d = in_fire ? gt : s1_gt_q;
    s1_eq_d = in_fire ? (in_a == in_b) : s1_eq_q;
    s1_oor_d = in_fire ? ({1'b0, in_chan} >= CH) : s1_oor_q;
    // a coincident clear makes the loading pair see a fresh history
    prev = (clear || s1_oor_q) ? 2'd0 : last_code_q[s1_chan_q];
    code = s1_oor_q ? 2'd0 : !s1_eq_q ? {1'b0, s1_gt_q} : (prev == 2'd2) ? 2'd3 : 2'd2;
    out_valid_d = s2_load || (out_valid_q && !out_ready);
    out_chan_d = s2_load ? s1_chan_q : out_chan_q;
    out_code_d = s2_load ? code : out_code_q;
    last_code_d = clear ? '0 : last_code_q;
    cnt_d = clear ? '0 : cnt_q;
    cur = cnt_d[s1_chan_q][code];
    if (s2_load && !s1_oor_q) begin
      last_code_d[s1_chan_q] = code;
      cnt_d[s1_chan_q][code] = &cur ? cur : cur + CNT_WIDTH'(1);
    end
    rd_count_d = ({1'b0, rd_chan} < CH) ? cnt_q[rd_chan][rd_sel] : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_gt_q     <= 1'b0;
      s1_eq_q     <= 1'b0;
      s1_oor_q    <= 1'b0;
      s1_chan_q   <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_code_q  <= '0;
      last_code_q <= '0;
      cnt_q       <= '0;
      rd_count_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_gt_q     <= s1_gt_d;
      s1_eq_q     <= s1_eq_d;
      s1_oor_q    <= s1_oor_d;
      s1_chan_q   <= s1_chan_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      out_code_q  <= out_code_d;
      last_code_q <= last_code_d;
      cnt_q       <= cnt_d;
      rd_count_q  <= rd_count_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign out_code  = out_code_q;
  assign rd_count  = rd_count_q;
endmodule

// File: tb/tb_cmp_classify_pipe.sv
// tb_cmp_classify_pipe: directed checks of classification, backpressure, signed
// compare, out-of-range channels, counter saturation, clear and async reset.
module tb_cmp_classify_pipe;
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, clear = 0;
  logic [1:0]  in_chan = 0, rd_chan = 0, rd_sel = 0;
  logic [15:0] in_a = 0, in_b = 0;
  logic        in_ready, out_valid, s_in_ready, s_out_valid;
  logic [1:0]  out_chan, out_code, s_out_chan, s_out_code;
  logic [2:0]  rd_count;
  logic [8:0]  s_rd_count;
  int          total = 0, passed = 0;
  logic [1:0]  cch [7] = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd2};
  logic [15:0] ca  [7] = '{16'd5, 16'd3, 16'd9, 16'd7, 16'd7, 16'd7, 16'd9};
  logic [15:0] cb  [7] = '{16'd3, 16'd5, 16'd9, 16'd7, 16'd7, 16'd7, 16'd9};
  logic [1:0]  cexp[7] = '{2'd1, 2'd0, 2'd2, 2'd2, 2'd3, 2'd2, 2'd3};

  always #5 clk = ~clk;

  cmp_classify_pipe #(.WIDTH(16), .CHANNELS(4), .CNT_WIDTH(3), .SIGNED(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_chan(in_chan),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
    .out_code(out_code), .clear(clear), .rd_chan(rd_chan), .rd_sel(rd_sel), .rd_count(rd_count));

  cmp_classify_pipe #(.WIDTH(16), .CHANNELS(3), .CNT_WIDTH(9), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_chan(in_chan),
    .in_a(in_a), .in_b(in_b), .out_valid(s_out_valid), .out_ready(out_ready), .out_chan(s_out_chan),
    .out_code(s_out_code), .clear(clear), .rd_chan(rd_chan), .rd_sel(rd_sel), .rd_count(s_rd_count));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] ch, input logic [15:0] a, input logic [15:0] b);
    in_valid = 1;
    in_chan = ch;
    in_a = a;
    in_b = b;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_chan", 32'(out_chan), 0);
    chk("rst_out_code", 32'(out_code), 0);
    chk("rst_rd_count", 32'(rd_count), 0);
    rst_n = 1;
    tick;
    for (int i = 0; i < 7; i++) begin
      drive(cch[i], ca[i], cb[i]);
      chk("cls_in_ready", 32'(in_ready), 1);
      tick;
      if (i > 0) begin
        chk("cls_valid", 32'(out_valid), 1);
        chk("cls_chan", 32'(out_chan), 32'(cch[i-1]));
        chk("cls_code", 32'(out_code), 32'(cexp[i-1]));
      end
    end
    in_valid = 0;
    tick;
    chk("cls_last_chan", 32'(out_chan), 2);
    chk("cls_last_code", 32'(out_code), 3);
    tick;
    chk("cls_drained", 32'(out_valid), 0);
    rd_chan = 1; rd_sel = 2; tick;
    chk("cnt_c1_s2", 32'(rd_count), 2);
    rd_sel = 3; tick;
    chk("cnt_c1_s3", 32'(rd_count), 1);
    rd_chan = 2; rd_sel = 2; tick;
    chk("cnt_c2_s2", 32'(rd_count), 1);
    out_ready = 0;
    drive(0, 16'd2, 16'd1); tick;
    drive(0, 16'd1, 16'd2); tick;
    chk("bp_in_ready_low", 32'(in_ready), 0);
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_code0", 32'(out_code), 1);
    drive(0, 16'd4, 16'd4); tick;
    chk("bp_hold_code", 32'(out_code), 1);
    chk("bp_hold_ready", 32'(in_ready), 0);
    tick;
    chk("bp_hold_code2", 32'(out_code), 1);
    chk("bp_hold_chan", 32'(out_chan), 0);
    out_ready = 1;
    #1;
    chk("bp_ready_back", 32'(in_ready), 1);
    tick;
    in_valid = 0;
    chk("bp_res1_valid", 32'(out_valid), 1);
    chk("bp_res1_code", 32'(out_code), 0);
    tick;
    chk("bp_res2_valid", 32'(out_valid), 1);
    chk("bp_res2_code", 32'(out_code), 2);
    tick;
    chk("bp_no_dup", 32'(out_valid), 0);
    drive(0, 16'hFFFF, 16'h0001); tick;
    in_valid = 0; tick;
    chk("unsigned_code", 32'(out_code), 1);
    chk("signed_code", 32'(s_out_code), 0);
    drive(3, 16'd5, 16'd5); tick;
    in_valid = 0; tick;
    chk("c3_code", 32'(out_code), 2);
    chk("oor_code", 32'(s_out_code), 0);
    chk("oor_chan", 32'(s_out_chan), 3);
    chk("oor_valid", 32'(s_out_valid), 1);
    rd_chan = 3; rd_sel = 2; tick;
    chk("c3_cnt", 32'(rd_count), 1);
    chk("oor_rd", 32'(s_rd_count), 0);
    rd_chan = 0; rd_sel = 1;
    for (int i = 0; i < 9; i++) begin
      drive(0, 16'd2, 16'd1);
      tick;
    end
    in_valid = 0;
    tick; tick;
    chk("cnt_sat", 32'(rd_count), 7);
    clear = 1; tick;
    clear = 0;
    chk("clear_pre_edge", 32'(rd_count), 7);
    tick;
    chk("clear_zero", 32'(rd_count), 0);
    drive(3, 16'd5, 16'd5); tick;
    in_valid = 0; tick;
    chk("post_clear_code", 32'(out_code), 2);
    drive(3, 16'd6, 16'd6); tick;
    in_valid = 0; clear = 1; tick;
    clear = 0;
    chk("coinc_code", 32'(out_code), 2);
    chk("coinc_chan", 32'(out_chan), 3);
    for (int c = 0; c < 4; c++)
      for (int s = 0; s < 4; s++) begin
        rd_chan = 2'(c); rd_sel = 2'(s); tick;
        chk($sformatf("coinc_cnt_%0d_%0d", c, s), 32'(rd_count), (c == 3 && s == 2) ? 1 : 0);
      end
    drive(3, 16'd8, 16'd8); tick;
    in_valid = 0; tick;
    chk("coinc_history", 32'(out_code), 3);
    rd_chan = 3; rd_sel = 3; tick;
    chk("pre_rst_rd", 32'(rd_count), 1);
    out_ready = 0;
    drive(1, 16'd1, 16'd2); tick;
    drive(1, 16'd2, 16'd1); tick;
    in_valid = 0;
    chk("pre_rst_valid", 32'(out_valid), 1);
    chk("pre_rst_ready", 32'(in_ready), 0);
    #2 rst_n = 0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_ready", 32'(in_ready), 1);
    chk("async_rst_rd", 32'(rd_count), 0);
    #1 rst_n = 1;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("no_stale", 32'(out_valid), 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
